// File: rtl/dma_arb_pkg.sv
// Shared state encoding and limits for the DMA channel arbiter.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_BUSY    = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    localparam int NUM_CH_MAX = 16;

endpackage

// File: rtl/dma_channel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req starting just after ptr, wrapping.
module rr_pick #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              found,
    output logic [CH_W-1:0]   idx
);

    logic [CH_W:0]       start;
    logic [NUM_CH-1:0]   rot;
    logic [CH_W-1:0]     off;
    logic [CH_W:0]       sum;

    // NOTE: every signal driven here gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        start = {1'b0, ptr} + (CH_W+1)'(1);
        // Shifting the doubled vector wraps the scan, so the channel at ptr itself is checked last.
        rot   = NUM_CH'({req, req} >> start);
        off   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = CH_W'(i);
            end
        end
        sum = start + {1'b0, off};
        if (sum >= (CH_W+1)'(NUM_CH)) begin
            sum = sum - (CH_W+1)'(NUM_CH);
        end
        found = |req;
        idx   = sum[CH_W-1:0];
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Round-robin DMA channel arbiter feeding both channel-FSM paths of the control unit.
// Optional watchdog forced release is enabled with `define DMA_ARB_WATCHDOG_EN.
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int TIMEOUT = 1024,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic              AXI_aclk,
    input  logic              AXI_areset,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              cfg_hold,
    input  logic              give1,
    input  logic              give2,
    output logic              arbitrate,
    output logic              validChannels,
    output logic              grant_vld,
    output logic [CH_W-1:0]   grant_id,
    output logic [NUM_CH-1:0] grant_onehot,
    output logic              timeout_err
);

    localparam logic [1:0] S_IDLE    = ARB_IDLE;
    localparam logic [1:0] S_GRANT   = ARB_GRANT;
    localparam logic [1:0] S_BUSY    = ARB_BUSY;
    localparam logic [1:0] S_RELEASE = ARB_RELEASE;

    if (NUM_CH < 2 || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("dma_channel_arbiter: NUM_CH out of range");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("dma_channel_arbiter: TIMEOUT must be at least 2");
    end

    logic [1:0]        state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   grant_id_q, grant_id_d;
    logic              give1_seen_q, give1_seen_d;
    logic              give2_seen_q, give2_seen_d;
    logic              valid_q;

    logic [NUM_CH-1:0] elig;
    logic              pick_found;
    logic [CH_W-1:0]   pick_idx;
    logic              give1_hit;
    logic              give2_hit;
    logic              both_given;
    logic              wd_expire;

    assign elig       = ch_req & ch_enable;
    assign give1_hit  = give1_seen_q | give1;
    assign give2_hit  = give2_seen_q | give2;
    assign both_given = give1_hit & give2_hit;

    rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_rr_pick (
        .req   (elig),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef DMA_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    assign wd_expire   = (state_q == S_BUSY) && (wd_cnt_q == WD_W'(TIMEOUT - 1));
    assign timeout_err = wd_expire && !both_given;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == S_GRANT) begin
            wd_cnt_d = '0;
        end else if (state_q == S_BUSY) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
        if (AXI_areset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        give1_seen_d = give1_seen_q;
        give2_seen_d = give2_seen_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found && !cfg_hold) begin
                    grant_id_d = pick_idx;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // Gives are only remembered here; a give in any other state is dropped.
                give1_seen_d = give1_hit;
                give2_seen_d = give2_hit;
                if (both_given || wd_expire) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                rr_ptr_d     = grant_id_q;
                give1_seen_d = 1'b0;
                give2_seen_d = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
        if (AXI_areset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= CH_W'(NUM_CH - 1);
            grant_id_q   <= '0;
            give1_seen_q <= 1'b0;
            give2_seen_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            give1_seen_q <= give1_seen_d;
            give2_seen_q <= give2_seen_d;
            valid_q      <= |elig;
        end
    end

    assign arbitrate     = (state_q == S_GRANT);
    assign grant_vld     = (state_q == S_GRANT) || (state_q == S_BUSY);
    assign grant_id      = grant_id_q;
    assign grant_onehot  = grant_vld ? (NUM_CH'(1) << grant_id_q) : '0;
    assign validChannels = valid_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed self-checking bench for dma_channel_arbiter (NUM_CH=4, TIMEOUT=16).
// Watchdog scenario runs only when DMA_ARB_WATCHDOG_EN is defined.
module tb_dma_channel_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] ch_req = '0;
    logic [3:0] ch_enable = '0;
    logic       cfg_hold = 1'b0;
    logic       give1 = 1'b0;
    logic       give2 = 1'b0;
    logic       arbitrate;
    logic       validChannels;
    logic       grant_vld;
    logic [1:0] grant_id;
    logic [3:0] grant_onehot;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    wire [9:0] all_outs = {arbitrate, validChannels, grant_vld, grant_id, grant_onehot, timeout_err};

    dma_channel_arbiter #(
        .NUM_CH  (4),
        .TIMEOUT (16)
    ) dut (
        .AXI_aclk      (clk),
        .AXI_areset    (rst),
        .ch_req        (ch_req),
        .ch_enable     (ch_enable),
        .cfg_hold      (cfg_hold),
        .give1         (give1),
        .give2         (give2),
        .arbitrate     (arbitrate),
        .validChannels (validChannels),
        .grant_vld     (grant_vld),
        .grant_id      (grant_id),
        .grant_onehot  (grant_onehot),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        ch_req    = '0;
        ch_enable = '0;
        cfg_hold  = 1'b0;
        give1     = 1'b0;
        give2     = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_arb(input int max_cycles, output int waited);
        waited = 0;
        while (arbitrate !== 1'b1 && waited < max_cycles) begin
            step();
            waited++;
        end
    endtask

    // From a GRANT cycle: one BUSY cycle with both gives, then RELEASE, ending in IDLE.
    task automatic release_grant();
        step();
        give1 = 1'b1;
        give2 = 1'b1;
        step();
        give1 = 1'b0;
        give2 = 1'b0;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (all_outs !== 10'd0) begin
            bad++;
            $display("FAIL reset_outs: got %0h expected 0", all_outs);
        end
        step();
        total++;
        if (all_outs !== 10'd0) begin
            bad++;
            $display("FAIL idle_outs: got %0h expected 0", all_outs);
        end
    endtask

    task automatic test_basic_grant();
        apply_reset();
        ch_enable = 4'hF;
        ch_req    = 4'b0101;
        total++;
        if (arbitrate !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_arb: got %0b expected 0", arbitrate);
        end
        step();
        total++;
        if ({arbitrate, grant_vld, grant_id, grant_onehot, validChannels} !== {1'b1, 1'b1, 2'd0, 4'b0001, 1'b1}) begin
            bad++;
            $display("FAIL basic_first_grant: got arb=%0b vld=%0b id=%0d oh=%b vc=%0b expected 1 1 0 0001 1",
                     arbitrate, grant_vld, grant_id, grant_onehot, validChannels);
        end
        step();
        total++;
        if ({arbitrate, grant_vld} !== 2'b01) begin
            bad++;
            $display("FAIL basic_busy: got arb=%0b vld=%0b expected 0 1", arbitrate, grant_vld);
        end
        give1 = 1'b1;
        give2 = 1'b1;
        step();
        give1 = 1'b0;
        give2 = 1'b0;
        total++;
        if ({grant_vld, grant_onehot} !== 5'b0) begin
            bad++;
            $display("FAIL basic_release: got vld=%0b oh=%b expected 0 0000", grant_vld, grant_onehot);
        end
        step();
        step();
        total++;
        if ({arbitrate, grant_id, grant_onehot} !== {1'b1, 2'd2, 4'b0100}) begin
            bad++;
            $display("FAIL basic_second_grant: got arb=%0b id=%0d oh=%b expected 1 2 0100",
                     arbitrate, grant_id, grant_onehot);
        end
        release_grant();
        ch_req = '0;
    endtask

    task automatic test_round_robin();
        int exp_id [5] = '{0, 1, 2, 3, 0};
        int waited;
        logic [3:0] exp_oh;
        apply_reset();
        ch_enable = 4'hF;
        ch_req    = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_arb(8, waited);
            exp_oh = 4'b0001 << exp_id[k];
            total++;
            if (arbitrate !== 1'b1 || waited !== 1 || grant_id !== 2'(exp_id[k]) || grant_onehot !== exp_oh) begin
                bad++;
                $display("FAIL rr_grant_%0d: got arb=%0b wait=%0d id=%0d oh=%b expected 1 1 %0d %b",
                         k, arbitrate, waited, grant_id, grant_onehot, exp_id[k], exp_oh);
            end
            step();
            total++;
            if (arbitrate !== 1'b0 || grant_vld !== 1'b1) begin
                bad++;
                $display("FAIL rr_pulse_%0d: got arb=%0b vld=%0b expected 0 1", k, arbitrate, grant_vld);
            end
            give1 = 1'b1;
            give2 = 1'b1;
            step();
            give1 = 1'b0;
            give2 = 1'b0;
            step();
        end
        ch_req = '0;
    endtask

    task automatic test_split_give();
        int waited;
        apply_reset();
        ch_enable = 4'hF;
        ch_req    = 4'b0100;
        wait_arb(4, waited);
        total++;
        if (arbitrate !== 1'b1 || grant_id !== 2'd2) begin
            bad++;
            $display("FAIL split_grant: got arb=%0b id=%0d expected 1 2", arbitrate, grant_id);
        end
        for (int c = 1; c <= 7; c++) begin
            step();
            total++;
            if (grant_vld !== 1'b1 || grant_id !== 2'd2 || grant_onehot !== 4'b0100) begin
                bad++;
                $display("FAIL split_busy_%0d: got vld=%0b id=%0d oh=%b expected 1 2 0100",
                         c, grant_vld, grant_id, grant_onehot);
            end
            give1 = (c == 2);
            give2 = (c == 7);
            if (c == 4) begin
                ch_req = '0;
            end
        end
        step();
        give2 = 1'b0;
        total++;
        if (grant_vld !== 1'b0) begin
            bad++;
            $display("FAIL split_release: got vld=%0b expected 0", grant_vld);
        end
        step();
        step();
        total++;
        if (arbitrate !== 1'b0 || grant_vld !== 1'b0) begin
            bad++;
            $display("FAIL split_no_regrant: got arb=%0b vld=%0b expected 0 0", arbitrate, grant_vld);
        end
    endtask

    task automatic test_cfg_hold();
        logic saw_arb = 1'b0;
        apply_reset();
        ch_enable = 4'hF;
        cfg_hold  = 1'b1;
        ch_req    = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            give1 = (c == 1);
            give2 = (c == 1);
            step();
            if (arbitrate === 1'b1 || grant_vld === 1'b1) saw_arb = 1'b1;
        end
        give1 = 1'b0;
        give2 = 1'b0;
        total++;
        if (validChannels !== 1'b1 || saw_arb !== 1'b0) begin
            bad++;
            $display("FAIL hold_blocks: got vc=%0b granted=%0b expected 1 0", validChannels, saw_arb);
        end
        cfg_hold = 1'b0;
        step();
        total++;
        if (arbitrate !== 1'b1 || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL hold_release_grant: got arb=%0b id=%0d expected 1 1", arbitrate, grant_id);
        end
        step();
        step();
        total++;
        if (grant_vld !== 1'b1) begin
            bad++;
            $display("FAIL idle_gives_ignored: got vld=%0b expected 1", grant_vld);
        end
        give1 = 1'b1;
        give2 = 1'b1;
        step();
        give1 = 1'b0;
        give2 = 1'b0;
        ch_req = '0;
        step();
    endtask

    task automatic test_disabled();
        logic saw_any = 1'b0;
        apply_reset();
        ch_enable = 4'b1011;
        ch_req    = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            step();
            if (validChannels !== 1'b0 || arbitrate !== 1'b0 || grant_vld !== 1'b0) saw_any = 1'b1;
        end
        total++;
        if (saw_any !== 1'b0) begin
            bad++;
            $display("FAIL disabled_no_grant: got activity=%0b expected 0", saw_any);
        end
        ch_enable = 4'hF;
        step();
        total++;
        if (arbitrate !== 1'b1 || grant_id !== 2'd2) begin
            bad++;
            $display("FAIL enabled_grant: got arb=%0b id=%0d expected 1 2", arbitrate, grant_id);
        end
        release_grant();
        ch_req = '0;
    endtask

    task automatic test_same_channel();
        apply_reset();
        ch_enable = 4'hF;
        ch_req    = 4'b1000;
        step();
        total++;
        if (arbitrate !== 1'b1 || grant_id !== 2'd3) begin
            bad++;
            $display("FAIL same_ch_first: got arb=%0b id=%0d expected 1 3", arbitrate, grant_id);
        end
        release_grant();
        step();
        total++;
        if (arbitrate !== 1'b1 || grant_id !== 2'd3 || grant_onehot !== 4'b1000) begin
            bad++;
            $display("FAIL same_ch_again: got arb=%0b id=%0d oh=%b expected 1 3 1000",
                     arbitrate, grant_id, grant_onehot);
        end
        release_grant();
        ch_req = '0;
    endtask

`ifdef DMA_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        apply_reset();
        ch_enable = 4'hF;
        ch_req    = 4'b0011;
        step();
        total++;
        if (arbitrate !== 1'b1 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL wd_grant: got arb=%0b id=%0d expected 1 0", arbitrate, grant_id);
        end
        for (int c = 1; c <= 16; c++) begin
            step();
            total++;
            if (timeout_err !== (c == 16) || grant_vld !== 1'b1) begin
                bad++;
                $display("FAIL wd_busy_%0d: got terr=%0b vld=%0b expected %0b 1",
                         c, timeout_err, grant_vld, (c == 16));
            end
        end
        step();
        total++;
        if (grant_vld !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL wd_release: got vld=%0b terr=%0b expected 0 0", grant_vld, timeout_err);
        end
        step();
        step();
        total++;
        if (arbitrate !== 1'b1 || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL wd_ptr_advance: got arb=%0b id=%0d expected 1 1", arbitrate, grant_id);
        end
        release_grant();
        ch_req = '0;
    endtask
`else
    task automatic test_no_watchdog();
        logic dropped = 1'b0;
        apply_reset();
        ch_enable = 4'hF;
        ch_req    = 4'b0001;
        step();
        for (int c = 0; c < 40; c++) begin
            step();
            if (grant_vld !== 1'b1 || timeout_err !== 1'b0) dropped = 1'b1;
        end
        total++;
        if (dropped !== 1'b0) begin
            bad++;
            $display("FAIL nowd_hold: got dropped=%0b expected 0", dropped);
        end
        give1 = 1'b1;
        give2 = 1'b1;
        step();
        give1 = 1'b0;
        give2 = 1'b0;
        ch_req = '0;
        step();
    endtask
`endif

    task automatic test_reset_mid_busy();
        apply_reset();
        ch_enable = 4'hF;
        ch_req    = 4'b0010;
        step();
        step();
        total++;
        if (grant_vld !== 1'b1 || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL midrst_busy: got vld=%0b id=%0d expected 1 1", grant_vld, grant_id);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (all_outs !== 10'd0) begin
            bad++;
            $display("FAIL midrst_async: got %0h expected 0", all_outs);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        total++;
        if (arbitrate !== 1'b1 || grant_id !== 2'd1) begin
            bad++;
            $display("FAIL midrst_regrant: got arb=%0b id=%0d expected 1 1", arbitrate, grant_id);
        end
        release_grant();
        ch_req = '0;
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_split_give();
        test_cfg_hold();
        test_disabled();
        test_same_channel();
`ifdef DMA_ARB_WATCHDOG_EN
        test_watchdog();
`else
        test_no_watchdog();
`endif
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
